sram_port_ctrl: RTL and testbench
=================================

// Module: sram_port_ctrl
// PURPOSE
//  Initiator-side controller for the 2R/2W 192-bit x 512 SRAM macro. Accepts up to two
//  client requests per cycle (ch0, ch1) over valid/ready, issues them on the SRAM
//  read/write ports, and returns read data over per-channel valid/ready response streams.
//  Sits between the datapath clients and the SRAM; the SRAM model has no reset.
// PARAMETERS
//  AW     9    SRAM address width (512 entries)
//  DW     192  SRAM data width
//  TW     4    request tag width, echoed on the read response
//  RDEPTH 2    response FIFO depth per channel (also the read credit count)
// PORTS
//  clock          in   1    single clock; all state on posedge
//  reset_n        in   1    asynchronous, active-low reset
//  reqN_valid     in   1    N=0,1: request valid
//  reqN_ready     out  1    request accepted when valid&ready
//  reqN_we        in   1    1=write, 0=read
//  reqN_addr      in   AW   request address
//  reqN_wdata     in   DW   write data
//  reqN_tag       in   TW   read tag
//  rspN_valid     out  1    read response valid
//  rspN_ready     in   1    response consumed when valid&ready
//  rspN_rdata     out  DW   read data
//  rspN_tag       out  TW   echoed tag
//  WE             out  1    SRAM shared write enable
//  WriteAddress1/2 out AW   SRAM write addresses
//  WriteBus1/2    out  DW   SRAM write data
//  ReadAddress1/2 out AW   SRAM read addresses (ch0->port1, ch1->port2)
//  ReadBus1/2     in   DW   SRAM read data, combinational, valid within the issue cycle
// BEHAVIOUR
//  - Reset: reqN_ready=0 during reset, 1 the cycle after release; rspN_valid=0; WE=0;
//    all SRAM address/data outputs 0; FIFOs empty; credits=RDEPTH.
//  - reqN_ready = (credN != 0), independent of reqN_valid/reqN_we. credN = RDEPTH minus
//    (FIFO occupancy + reads in issue stage). Credit taken at accept, returned at rsp pop.
//  - Pipeline: accept edge E0 loads the issue register; during cycle E0..E1 the issue
//    register drives SRAM ports; at E1 writes commit in the SRAM and read data is pushed
//    into rspN FIFO. rspN_valid rises after E1: accept-to-response latency = 2 cycles.
//  - Shared WE: WE=1 iff at least one issued op is a write. One write only: both write
//    ports carry that write's addr/data. Two writes: ch0 on port1, ch1 on port2; same
//    address -> both ports carry ch1 (ch1 wins, deterministic).
//  - Read ports idle (no read issued): hold last address, no FIFO push.
//  - Same-cycle read and write to the same address: read returns the OLD data (read-first).
//  - FIFO: push and pop in the same cycle on a full FIFO is legal (occupancy unchanged).
//    Overflow is impossible by credit; a push on full is an assertion failure.
//  - Response order within a channel = request order. No ordering between channels.
//  - Reset mid-operation: in-flight reads and FIFO contents are discarded. An issued but
//    uncommitted write is dropped because WE is forced to 0 asynchronously.
// CONFIGURATION
//  - SRAM_PORT_CTRL_FWD_EN defined: a read issued in the same cycle as a write to the
//    same address returns the NEW write data. The ch1 write wins if both channels write
//    that address. This is forwarding inside the controller.
//  - SRAM_PORT_CTRL_FWD_EN undefined: read-first, as above. No forwarding logic is built.
// STRUCTURE
//  - Package sram_ctrl_pkg: AW/DW/TW constants, typedef req_t {we,addr,wdata,tag},
//    typedef rsp_t {rdata,tag}.
//  - Sub-module sram_rsp_fifo: parameterised DEPTH/width sync FIFO with full/empty/count.
//    Instantiated once per channel.
//  - Top-level logic: credit counters, issue register, write-port merge, optional forwarding.
// TESTING
//  1. Reset release, then ch0 write 0x1A5 with data A, then a ch0 read of 0x1A5 (tag 3)
//     -> rsp0 returns A with tag 3, exactly 2 cycles after the read accept.
//  2. Both channels write address 0x010 in the same cycle (ch0=B, ch1=C), then a read
//     -> WE pulses once and the read returns C.
//  3. Single ch1 write to 0x0FF with data D -> WriteAddress1=WriteAddress2=0x0FF and
//     WriteBus1=WriteBus2=D for that cycle.
//  4. rsp0_ready held 0 while ch0 issues 3 reads -> req0_ready drops after the 2nd accept.
//     Releasing ready pops in order; the 3rd read is accepted after the first pop.
//  5. Same-cycle ch0 read and ch1 write of E to 0x020 (old value F) -> rsp0 = F without
//     FWD_EN, rsp0 = E with FWD_EN.
//  6. Assert reset_n low with 2 reads in flight -> rsp valids 0, WE 0 immediately.
//     After release, credits are back to RDEPTH and no stale responses appear.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared widths and request/response records for the SRAM port controller.
package sram_ctrl_pkg;
  localparam int AW     = 9;
  localparam int DW     = 192;
  localparam int TW     = 4;
  localparam int RDEPTH = 2;
  localparam int CREDW  = $clog2(RDEPTH + 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [TW-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [TW-1:0] tag;
  } rsp_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding read responses for one channel.
// A push and a pop in the same cycle on a full FIFO is legal.
module sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= pushData;
  end

  assign popData = mem[rdPtr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  assert property (@(posedge clock) disable iff (!reset_n) !(push && full && !pop));
endmodule

// File: rtl/sram_port_ctrl.sv
// Two-channel initiator for the 2R/2W SRAM macro: credit flow control, one issue stage, response FIFOs.
// Optional build macro SRAM_PORT_CTRL_FWD_EN forwards same-cycle write data to a colliding read.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic [TW-1:0] req0_tag,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic [TW-1:0] req1_tag,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_rdata,
  output logic [TW-1:0] rsp0_tag,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_rdata,
  output logic [TW-1:0] rsp1_tag,
  output logic          WE,
  output logic [AW-1:0] WriteAddress1,
  output logic [AW-1:0] WriteAddress2,
  output logic [DW-1:0] WriteBus1,
  output logic [DW-1:0] WriteBus2,
  output logic [AW-1:0] ReadAddress1,
  output logic [AW-1:0] ReadAddress2,
  input  logic [DW-1:0] ReadBus1,
  input  logic [DW-1:0] ReadBus2
);
  logic             running;
  logic [1:0]       reqValid, reqReady, rspReady, rspValid;
  logic [1:0]       accept, rdAccept, pop, push, wrEn;
  req_t             reqIn    [2];
  req_t             issReq   [2];
  logic             issValid [2];
  logic [CREDW-1:0] cred     [2];
  logic [AW-1:0]    rdAddr   [2];
  logic [DW-1:0]    readBus  [2];
  rsp_t             pushData [2];
  rsp_t             popData  [2];
  logic             fifoEmpty[2];
  logic             fifoFull [2];
  logic [CREDW-1:0] fifoCount[2];

  assign reqIn[0] = '{we: req0_we, addr: req0_addr, wdata: req0_wdata, tag: req0_tag};
  assign reqIn[1] = '{we: req1_we, addr: req1_addr, wdata: req1_wdata, tag: req1_tag};
  assign readBus[0] = ReadBus1;
  assign readBus[1] = ReadBus2;

  // Holds ready low through reset and for the release edge itself.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) running <= 1'b0;
    else          running <= 1'b1;
  end

  assign reqValid = {req1_valid, req0_valid};
  assign rspReady = {rsp1_ready, rsp0_ready};
  assign reqReady = {running & (cred[1] != '0), running & (cred[0] != '0)};
  assign accept   = reqValid & reqReady;
  assign rdAccept = accept & ~{reqIn[1].we, reqIn[0].we};
  assign rspValid = {~fifoEmpty[1], ~fifoEmpty[0]};
  assign pop      = rspValid & rspReady;
  assign push     = {issValid[1] & ~issReq[1].we, issValid[0] & ~issReq[0].we};
  assign wrEn     = {issValid[1] & issReq[1].we, issValid[0] & issReq[0].we};

  for (genvar ch = 0; ch < 2; ch++) begin : gChan
    logic [DW-1:0] rdData;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cred[ch]     <= CREDW'(RDEPTH);
        issValid[ch] <= 1'b0;
        issReq[ch]   <= '0;
        rdAddr[ch]   <= '0;
      end else begin
        cred[ch]     <= cred[ch] - CREDW'(rdAccept[ch]) + CREDW'(pop[ch]);
        issValid[ch] <= accept[ch];
        if (accept[ch])   issReq[ch] <= reqIn[ch];
        if (rdAccept[ch]) rdAddr[ch] <= reqIn[ch].addr;
      end
    end

`ifdef SRAM_PORT_CTRL_FWD_EN
    // ch1 is checked last so it wins when both channels write the read address.
    always_comb begin
      rdData = readBus[ch];
      if (wrEn[0] && issReq[0].addr == rdAddr[ch]) rdData = issReq[0].wdata;
      if (wrEn[1] && issReq[1].addr == rdAddr[ch]) rdData = issReq[1].wdata;
    end
`else
    assign rdData = readBus[ch];
`endif

    assign pushData[ch] = '{rdata: rdData, tag: issReq[ch].tag};

    sram_rsp_fifo #(.DEPTH(RDEPTH), .WIDTH($bits(rsp_t))) uRspFifo (
      .clock    (clock),
      .reset_n  (reset_n),
      .push     (push[ch]),
      .pushData (pushData[ch]),
      .pop      (pop[ch]),
      .popData  (popData[ch]),
      .full     (fifoFull[ch]),
      .empty    (fifoEmpty[ch]),
      .count    (fifoCount[ch])
    );

    assert property (@(posedge clock) disable iff (!reset_n)
      ((32'(cred[ch]) + 32'(fifoCount[ch]) + 32'(push[ch])) == RDEPTH) &&
      (!fifoFull[ch] || cred[ch] == '0));
  end

  // Shared WE means both write ports always commit; a lone write is mirrored on both.
  always_comb begin
    WE            = |wrEn;
    WriteAddress1 = '0;
    WriteAddress2 = '0;
    WriteBus1     = '0;
    WriteBus2     = '0;
    if (wrEn[0] && wrEn[1]) begin
      WriteAddress1 = issReq[0].addr;
      WriteBus1     = issReq[0].wdata;
      WriteAddress2 = issReq[1].addr;
      WriteBus2     = issReq[1].wdata;
      if (issReq[0].addr == issReq[1].addr) WriteBus1 = issReq[1].wdata;
    end else if (wrEn[1]) begin
      WriteAddress1 = issReq[1].addr;
      WriteBus1     = issReq[1].wdata;
      WriteAddress2 = issReq[1].addr;
      WriteBus2     = issReq[1].wdata;
    end else if (wrEn[0]) begin
      WriteAddress1 = issReq[0].addr;
      WriteBus1     = issReq[0].wdata;
      WriteAddress2 = issReq[0].addr;
      WriteBus2     = issReq[0].wdata;
    end
  end

  assign ReadAddress1 = rdAddr[0];
  assign ReadAddress2 = rdAddr[1];
  assign req0_ready   = reqReady[0];
  assign req1_ready   = reqReady[1];
  assign rsp0_valid   = rspValid[0];
  assign rsp1_valid   = rspValid[1];
  assign rsp0_rdata   = popData[0].rdata;
  assign rsp0_tag     = popData[0].tag;
  assign rsp1_rdata   = popData[1].rdata;
  assign rsp1_tag     = popData[1].tag;
endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural 2R/2W SRAM (no reset, read-first).
module tb_sram_port_ctrl;
  import sram_ctrl_pkg::*;

  localparam logic [DW-1:0] DATA_A = {6{32'hA5A5_0001}};
  localparam logic [DW-1:0] DATA_B = {6{32'hB0B0_0002}};
  localparam logic [DW-1:0] DATA_C = {6{32'hC3C3_0003}};
  localparam logic [DW-1:0] DATA_D = {6{32'hD4D4_0004}};
  localparam logic [DW-1:0] DATA_E = {6{32'hE5E5_0005}};
  localparam logic [DW-1:0] DATA_F = {6{32'hF6F6_0006}};
  localparam logic [DW-1:0] DATA_G = {6{32'h1717_0007}};
`ifdef SRAM_PORT_CTRL_FWD_EN
  localparam logic [DW-1:0] COLLIDE_EXP = DATA_E;
`else
  localparam logic [DW-1:0] COLLIDE_EXP = DATA_F;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic [TW-1:0] req0_tag, req1_tag;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [TW-1:0] rsp0_tag, rsp1_tag;
  logic          WE;
  logic [AW-1:0] WriteAddress1, WriteAddress2, ReadAddress1, ReadAddress2;
  logic [DW-1:0] WriteBus1, WriteBus2, ReadBus1, ReadBus2;
  logic [DW-1:0] sramMem [512];
  int            numChecks;
  int            numFails;

  always #5 clock = ~clock;

  sram_port_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata), .rsp1_tag(rsp1_tag),
    .WE(WE), .WriteAddress1(WriteAddress1), .WriteAddress2(WriteAddress2),
    .WriteBus1(WriteBus1), .WriteBus2(WriteBus2),
    .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
    .ReadBus1(ReadBus1), .ReadBus2(ReadBus2)
  );

  always @(posedge clock) begin
    if (WE) begin
      sramMem[WriteAddress1] <= WriteBus1;
      sramMem[WriteAddress2] <= WriteBus2;
    end
  end
  assign ReadBus1 = sramMem[ReadAddress1];
  assign ReadBus2 = sramMem[ReadAddress2];

  task automatic checkVal(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int ch, input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [TW-1:0] t);
    if (ch == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_tag = t;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_tag = t;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    numChecks = 0;
    numFails  = 0;
    for (int i = 0; i < 512; i++) sramMem[i] = '0;
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    checkVal("rst_req0_ready", req0_ready, 0);
    checkVal("rst_req1_ready", req1_ready, 0);
    checkVal("rst_rsp0_valid", rsp0_valid, 0);
    checkVal("rst_rsp1_valid", rsp1_valid, 0);
    checkVal("rst_we", WE, 0);
    checkVal("rst_waddr1", WriteAddress1, 0);
    checkVal("rst_raddr2", ReadAddress2, 0);
    reset_n = 1'b1;
    checkVal("rel_ready_before_edge", req0_ready, 0);
    tick();
    checkVal("rel_req0_ready", req0_ready, 1);
    checkVal("rel_req1_ready", req1_ready, 1);

    // 1: write then read back on ch0
    drive(0, 1, 1, 9'h1A5, DATA_A, 0);
    tick();
    checkVal("t1_we", WE, 1);
    checkVal("t1_waddr1", WriteAddress1, 9'h1A5);
    checkVal("t1_waddr2", WriteAddress2, 9'h1A5);
    checkVal("t1_wbus1", WriteBus1, DATA_A);
    drive(0, 1, 0, 9'h1A5, '0, 3);
    tick();
    drive(0, 0, 0, '0, '0, '0);
    checkVal("t1_rsp_not_yet", rsp0_valid, 0);
    checkVal("t1_raddr1", ReadAddress1, 9'h1A5);
    checkVal("t1_we_low", WE, 0);
    tick();
    checkVal("t1_rsp_valid", rsp0_valid, 1);
    checkVal("t1_rsp_data", rsp0_rdata, DATA_A);
    checkVal("t1_rsp_tag", rsp0_tag, 3);
    tick();
    checkVal("t1_rsp_popped", rsp0_valid, 0);

    // 2: both channels write the same address, ch1 wins
    drive(0, 1, 1, 9'h010, DATA_B, 0);
    drive(1, 1, 1, 9'h010, DATA_C, 0);
    tick();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    checkVal("t2_we", WE, 1);
    checkVal("t2_wbus1", WriteBus1, DATA_C);
    checkVal("t2_wbus2", WriteBus2, DATA_C);
    checkVal("t2_waddr1", WriteAddress1, 9'h010);
    tick();
    checkVal("t2_we_once", WE, 0);
    drive(1, 1, 0, 9'h010, '0, 5);
    tick();
    drive(1, 0, 0, '0, '0, '0);
    tick();
    checkVal("t2_rsp1_valid", rsp1_valid, 1);
    checkVal("t2_rsp1_data", rsp1_rdata, DATA_C);
    checkVal("t2_rsp1_tag", rsp1_tag, 5);
    tick();

    // 3: single ch1 write mirrored on both ports
    drive(1, 1, 1, 9'h0FF, DATA_D, 0);
    tick();
    drive(1, 0, 0, '0, '0, '0);
    checkVal("t3_waddr1", WriteAddress1, 9'h0FF);
    checkVal("t3_waddr2", WriteAddress2, 9'h0FF);
    checkVal("t3_wbus1", WriteBus1, DATA_D);
    checkVal("t3_wbus2", WriteBus2, DATA_D);
    tick();

    // 4: back-pressure exhausts ch0 credits
    rsp0_ready = 1'b0;
    drive(0, 1, 0, 9'h1A5, '0, 1);
    tick();
    checkVal("t4_ready_after1", req0_ready, 1);
    drive(0, 1, 0, 9'h010, '0, 2);
    tick();
    checkVal("t4_ready_after2", req0_ready, 0);
    drive(0, 1, 0, 9'h0FF, '0, 3);
    tick();
    checkVal("t4_ready_held", req0_ready, 0);
    tick();
    checkVal("t4_head_tag", rsp0_tag, 1);
    checkVal("t4_head_data", rsp0_rdata, DATA_A);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    checkVal("t4_second_tag", rsp0_tag, 2);
    checkVal("t4_second_data", rsp0_rdata, DATA_C);
    checkVal("t4_ready_back", req0_ready, 1);
    tick();
    drive(0, 0, 0, '0, '0, '0);
    checkVal("t4_third_taken", req0_ready, 0);
    tick();
    rsp0_ready = 1'b1;
    tick();
    checkVal("t4_third_tag", rsp0_tag, 3);
    checkVal("t4_third_data", rsp0_rdata, DATA_D);
    tick();
    checkVal("t4_drained", rsp0_valid, 0);
    checkVal("t4_ready_full", req0_ready, 1);

    // 5: same-cycle read and write to one address
    drive(0, 1, 1, 9'h020, DATA_F, 0);
    tick();
    drive(0, 1, 0, 9'h020, '0, 7);
    drive(1, 1, 1, 9'h020, DATA_E, 0);
    tick();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    tick();
    checkVal("t5_collide_data", rsp0_rdata, COLLIDE_EXP);
    checkVal("t5_collide_tag", rsp0_tag, 7);
    tick();
    drive(0, 1, 0, 9'h020, '0, 8);
    tick();
    drive(0, 0, 0, '0, '0, '0);
    tick();
    checkVal("t5_after_data", rsp0_rdata, DATA_E);
    tick();

    // 6: reset with reads and a write in flight
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    drive(0, 1, 0, 9'h1A5, '0, 1);
    drive(1, 1, 0, 9'h010, '0, 2);
    tick();
    drive(0, 1, 0, 9'h0FF, '0, 4);
    drive(1, 1, 1, 9'h1A5, DATA_G, 0);
    tick();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    checkVal("t6_we_before", WE, 1);
    reset_n = 1'b0;
    #1;
    checkVal("t6_we_async", WE, 0);
    checkVal("t6_rsp0_async", rsp0_valid, 0);
    checkVal("t6_rsp1_async", rsp1_valid, 0);
    checkVal("t6_ready_async", req0_ready, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checkVal("t6_req0_ready", req0_ready, 1);
    checkVal("t6_req1_ready", req1_ready, 1);
    checkVal("t6_no_stale0", rsp0_valid, 0);
    checkVal("t6_no_stale1", rsp1_valid, 0);
    drive(0, 1, 0, 9'h1A5, '0, 9);
    tick();
    checkVal("t6_cred_left", req0_ready, 1);
    drive(0, 1, 0, 9'h010, '0, 10);
    tick();
    drive(0, 0, 0, '0, '0, '0);
    checkVal("t6_cred_gone", req0_ready, 0);
    tick();
    checkVal("t6_rsp_valid", rsp0_valid, 1);
    checkVal("t6_write_dropped", rsp0_rdata, DATA_A);
    checkVal("t6_rsp_tag", rsp0_tag, 9);
    rsp0_ready = 1'b1;
    tick();
    checkVal("t6_second_tag", rsp0_tag, 10);
    checkVal("t6_second_data", rsp0_rdata, DATA_C);
    tick();
    checkVal("t6_drained", rsp0_valid, 0);
    checkVal("t6_ready_end", req0_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end
endmodule
